// File: rtl/safe_pkg.sv
// Shared types and constants for the keypad safe sequencer.
// State codes, key codes and the factory password digit.
package safe_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_SET     = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_SHARP = 4'd11;
  localparam logic [3:0] DEF_DIGIT = 4'd0;

  function automatic logic is_digit(logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/safe_if.sv
// Keypad input and status output bundle of the safe sequencer.
// master drives keys, slave is the sequencer.
interface safe_if #(
  parameter int PW_LEN = 6
);
  logic              key_valid;
  logic [3:0]        key_code;
  logic              set_mode;
  logic [PW_LEN-1:0] digit_led;
  logic [2:0]        state;
  logic              unlocked;
  logic              alarm;

  modport master (
    output key_valid, key_code, set_mode,
    input  digit_led, state, unlocked, alarm
  );

  modport slave (
    input  key_valid, key_code, set_mode,
    output digit_led, state, unlocked, alarm
  );
endinterface

// File: rtl/safe_lock_timer.sv
// Lockout down-counter: load, decrement while enabled,
// expiry pulse when enabled at zero.
module safe_lock_timer #(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          en,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  assign expired = en && !load && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/safe_sequencer.sv
// Keypad safe: password entry, set-password mode and
// timed lockout after repeated wrong submissions.
module safe_sequencer
  import safe_pkg::*;
#(
  parameter int PW_LEN      = 6,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input logic   clk,
  input logic   reset_n,
  safe_if.slave bus
);

  localparam int CW = $clog2(PW_LEN + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int BW = 4 * PW_LEN;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     buf_q, buf_d;
  logic [BW-1:0]     pw_q, pw_d;
  logic [FW-1:0]     fail_q, fail_d, fail_inc;
  logic [PW_LEN-1:0] led_q, led_d;
  logic              unl_q, unl_d;
  logic              alm_q, alm_d;
  logic              tmr_load, tmr_en, tmr_exp;
  logic              dig, star, sharp, full;

  safe_lock_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (TW'(LOCK_CYCLES - 1)),
    .expired  (tmr_exp)
  );

  assign dig      = bus.key_valid && is_digit(bus.key_code);
  assign star     = bus.key_valid && (bus.key_code == KEY_STAR);
  assign sharp    = bus.key_valid && (bus.key_code == KEY_SHARP);
  assign full     = (cnt_q == CW'(PW_LEN));
  assign fail_inc = fail_q + 1'b1;
  assign tmr_en   = (state_q == ST_LOCKOUT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    pw_d     = pw_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    // digits append in ENTRY/SET; dropped once the buffer is full
    if ((state_q == ST_ENTRY || state_q == ST_SET) && dig && !full) begin
      for (int i = 0; i < PW_LEN; i++)
        if (int'(cnt_q) == i) buf_d[4*i +: 4] = bus.key_code;
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      ST_LOCKED: begin
        if (dig) begin
          buf_d       = '0;
          buf_d[3:0]  = bus.key_code;
          cnt_d       = CW'(1);
          state_d     = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (star) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_LOCKED;
        end else if (sharp) begin
          buf_d = '0;
          cnt_d = '0;
          if (full && buf_q == pw_q) begin
            fail_d  = '0;
            state_d = ST_OPEN;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == FW'(MAX_FAIL)) begin
              tmr_load = 1'b1;
              state_d  = ST_LOCKOUT;
            end else begin
              state_d  = ST_LOCKED;
            end
          end
        end
      end
      ST_OPEN: begin
        if (sharp) begin
          state_d = ST_LOCKED;
        end else if (star && bus.set_mode) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_SET;
        end
      end
      ST_SET: begin
        if (sharp || star) begin
          if (sharp && full) pw_d = buf_q;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_exp) begin
          fail_d  = '0;
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
    for (int i = 0; i < PW_LEN; i++)
      led_d[i] = (int'(cnt_d) > i);
    unl_d = (state_d == ST_OPEN) || (state_d == ST_SET);
    alm_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_LOCKED;
      cnt_q   <= '0;
      buf_q   <= '0;
      pw_q    <= {PW_LEN{DEF_DIGIT}};
      fail_q  <= '0;
      led_q   <= '0;
      unl_q   <= 1'b0;
      alm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      pw_q    <= pw_d;
      fail_q  <= fail_d;
      led_q   <= led_d;
      unl_q   <= unl_d;
      alm_q   <= alm_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.digit_led = led_q;
  assign bus.unlocked  = unl_q;
  assign bus.alarm     = alm_q;

endmodule

// File: tb/tb_safe_sequencer.sv
// Directed bench for safe_sequencer: entry, set, lockout,
// ignored keys and asynchronous reset.
module tb_safe_sequencer;
  import safe_pkg::*;

  localparam int LOCK = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_lock;

  safe_if #(.PW_LEN(6)) bus ();

  safe_sequencer #(
    .PW_LEN      (6),
    .MAX_FAIL    (3),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(string tag, logic [2:0] st, logic [5:0] led,
                      logic unl, logic alm);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".led"}, 32'(bus.digit_led), 32'(led));
    chk({tag, ".unlocked"}, 32'(bus.unlocked), 32'(unl));
    chk({tag, ".alarm"}, 32'(bus.alarm), 32'(alm));
  endtask

  task automatic press(logic [3:0] k);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic enter6(string tag, logic [23:0] pw, logic [2:0] st);
    for (int i = 0; i < 6; i++) begin
      press(pw[4*i +: 4]);
      chk({tag, ".state"}, 32'(bus.state), 32'(st));
      chk({tag, ".led"}, 32'(bus.digit_led), (32'd1 << (i + 1)) - 1);
    end
  endtask

  task automatic wrong123();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(KEY_SHARP);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.set_mode  = 1'b0;
    #1;
    outs("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    press(4'd13);
    outs("inv_locked", 0, 0, 0, 0);
    press(KEY_STAR);
    press(KEY_SHARP);
    outs("locked_star_sharp", 0, 0, 0, 0);

    enter6("entry0", 24'h000000, 1);
    press(4'd7);
    outs("entry_7th", 1, 6'h3f, 0, 0);
    press(4'd13);
    outs("inv_entry", 1, 6'h3f, 0, 0);
    press(KEY_SHARP);
    outs("open", 2, 0, 1, 0);

    press(4'd13);
    outs("inv_open", 2, 0, 1, 0);
    press(4'd3);
    outs("open_digit", 2, 0, 1, 0);
    press(KEY_STAR);
    outs("open_star_noset", 2, 0, 1, 0);

    bus.set_mode = 1'b1;
    press(KEY_STAR);
    outs("set", 3, 0, 1, 0);
    press(4'd13);
    outs("inv_set", 3, 0, 1, 0);
    enter6("set_pw", 24'h456789, 3);
    press(KEY_SHARP);
    outs("set_commit", 2, 0, 1, 0);
    press(KEY_SHARP);
    outs("relock", 0, 0, 0, 0);
    bus.set_mode = 1'b0;

    enter6("new_pw", 24'h456789, 1);
    press(KEY_SHARP);
    outs("open_new", 2, 0, 1, 0);

    bus.set_mode = 1'b1;
    press(KEY_STAR);
    press(4'd1);
    press(4'd2);
    outs("set_partial", 3, 6'h03, 1, 0);
    press(KEY_SHARP);
    outs("set_abort", 2, 0, 1, 0);
    press(KEY_SHARP);
    bus.set_mode = 1'b0;
    enter6("kept_pw", 24'h456789, 1);
    press(KEY_SHARP);
    outs("open_kept", 2, 0, 1, 0);
    press(KEY_SHARP);

    enter6("old_pw", 24'h000000, 1);
    press(KEY_SHARP);
    outs("old_pw_fail", 0, 0, 0, 0);
    enter6("full", 24'h111111, 1);
    press(4'd2);
    outs("full_7th", 1, 6'h3f, 0, 0);
    press(KEY_STAR);
    outs("entry_star", 0, 0, 0, 0);
    wrong123();
    outs("fail2", 0, 0, 0, 0);
    wrong123();
    outs("lockout", 4, 0, 0, 1);

    n_lock        = 1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd5;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.alarm) break;
      n_lock++;
    end
    bus.key_valid = 1'b0;
    chk("lock_len", 32'(n_lock), 32'(LOCK));
    outs("lock_exit", 0, 0, 0, 0);

    wrong123();
    outs("retry1", 0, 0, 0, 0);
    wrong123();
    outs("retry2", 0, 0, 0, 0);
    wrong123();
    outs("retry3", 4, 0, 0, 1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    outs("rst_lockout", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    enter6("pw_rst1", 24'h000000, 1);
    press(KEY_SHARP);
    outs("open_rst1", 2, 0, 1, 0);
    bus.set_mode = 1'b1;
    press(KEY_STAR);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    outs("set_mid", 3, 6'h07, 1, 0);
    reset_n = 1'b0;
    #1;
    outs("rst_set", 0, 0, 0, 0);
    @(negedge clk);
    reset_n      = 1'b1;
    bus.set_mode = 1'b0;
    enter6("pw_rst2", 24'h000000, 1);
    press(KEY_SHARP);
    outs("open_rst2", 2, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
